// File: rtl/isa_pkg.sv
// Opcode constants shared by the decode-stage flag generator and the
// control encoder, plus the expected writeback value for each opcode.
package isa_pkg;

  localparam logic [3:0] ADD_OP = 4'd0;
  localparam logic [3:0] SUB_OP = 4'd1;
  localparam logic [3:0] MUL_OP = 4'd2;
  localparam logic [3:0] LD_OP  = 4'd3;
  localparam logic [3:0] ST_OP  = 4'd4;
  localparam logic [3:0] CMP_OP = 4'd5;
  localparam logic [3:0] MOV_OP = 4'd6;
  localparam logic [3:0] OR_OP  = 4'd7;
  localparam logic [3:0] AND_OP = 4'd8;
  localparam logic [3:0] NOT_OP = 4'd9;
  localparam logic [3:0] LSL_OP = 4'd10;
  localparam logic [3:0] LSR_OP = 4'd11;
  localparam logic [3:0] UBR_OP = 4'd12;
  localparam logic [3:0] BEQ_OP = 4'd13;
  localparam logic [3:0] BGT_OP = 4'd14;
  localparam logic [3:0] WB_OP  = 4'd15;

  function automatic logic exp_wb(input logic [3:0] op);
    logic r;
    case (op)
      ADD_OP, SUB_OP, MUL_OP, LD_OP, MOV_OP,
      OR_OP, AND_OP, NOT_OP, LSL_OP, LSR_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// DEPTH x W synchronous FIFO with a registered head output.
// Ports: clk, reset, push, pop, din, dout (head), count, empty.
module ctrl_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  import isa_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_dout;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_head_nx;
  logic [CW-1:0] w_left;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push    = push && (r_count < CW'(DEPTH));
  assign w_pop     = pop && (r_count != '0);
  assign w_head_nx = w_pop ? inc(r_head) : r_head;
  // entries remaining after the pop, before the push lands
  assign w_left    = r_count - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_push) r_tail <= inc(r_tail);
      r_head  <= w_head_nx;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // the head register tracks the next head; holds when draining empty
      if (w_left == '0) begin
        if (w_push) r_dout <= din;
      end else begin
        r_dout <= r_mem[w_head_nx];
      end
    end
  end

  assign dout  = r_dout;
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/control_encoder.sv
// Re-encodes a one-hot control bundle to a 4-bit opcode, buffers legal
// bundles and drops/counts illegal ones. Ports: in/out valid-ready pair,
// op flags + iswb in, out_opcode/out_wb head, err_pulse, err_count.
module control_encoder #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             isadd,
  input  logic             issub,
  input  logic             ismul,
  input  logic             isld,
  input  logic             isst,
  input  logic             iscmp,
  input  logic             ismov,
  input  logic             isor,
  input  logic             isand,
  input  logic             isnot,
  input  logic             islsl,
  input  logic             islsr,
  input  logic             isxor,
  input  logic             isbeq,
  input  logic             isbgt,
  input  logic             isubranch,
  input  logic             iswb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic             out_wb,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);
  import isa_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]      w_all;
  logic [3:0]       w_op;
  logic             w_legal;
  logic             w_acc;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic [4:0]       w_head;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  assign w_all = {isxor, isbgt, isbeq, isubranch, islsr, islsl, isnot,
                  isand, isor, ismov, iscmp, isst, isld, ismul, issub,
                  isadd};

  // first-match encode; multi-hot bundles are rejected below anyway
  always_comb begin
    w_op = WB_OP;
    case (1'b1)
      isadd:     w_op = ADD_OP;
      issub:     w_op = SUB_OP;
      ismul:     w_op = MUL_OP;
      isld:      w_op = LD_OP;
      isst:      w_op = ST_OP;
      iscmp:     w_op = CMP_OP;
      ismov:     w_op = MOV_OP;
      isor:      w_op = OR_OP;
      isand:     w_op = AND_OP;
      isnot:     w_op = NOT_OP;
      islsl:     w_op = LSL_OP;
      islsr:     w_op = LSR_OP;
      isubranch: w_op = UBR_OP;
      isbeq:     w_op = BEQ_OP;
      isbgt:     w_op = BGT_OP;
      default:   w_op = WB_OP;
    endcase
  end

  assign w_legal = ($countones(w_all) <= 1) && !isxor &&
                   (iswb == exp_wb(w_op));
  assign in_ready = (w_count < CW'(DEPTH));
  assign w_acc    = in_valid && in_ready;
  assign out_valid = !w_empty;

  ctrl_fifo #(.DEPTH(DEPTH), .W(5), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_acc && w_legal),
    .pop   (out_valid && out_ready),
    .din   ({iswb, w_op}),
    .dout  (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_acc && !w_legal;
      if (w_acc && !w_legal && (r_err_count != '1))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_opcode = w_head[3:0];
  assign out_wb     = w_head[4];
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule
